mem_access_stage: RTL and testbench

- Memory-access stage of the 5-stage RISC-V pipeline.
- Sits between the execute stage and the register file write port.
- Performs loads and stores byte-serially over the 8-bit RAM bus, and sign- or zero-extends load data.
- Drives the registered write-back triple (wb_wa/wb_wn/wb_we) that feeds the register file's write port, and stalls upstream while busy.

---
 rtl/mem_access_stage_if.sv | 31 +++
 rtl/mem_access_stage.sv | 203 ++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// Bundle of execute-side, RAM-side and write-back signals of the memory-access stage.
// The stage itself connects through the master modport.
interface mem_access_stage_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  ex_valid;
  logic [3:0]            ex_memop;
  logic [31:0]           ex_addr;
  logic [31:0]           ex_sdata;
  logic [4:0]            ex_wa;
  logic [31:0]           ex_wn;
  logic                  ex_we;
  logic [7:0]            ram_din;
  logic [ADDR_WIDTH-1:0] ram_a;
  logic [7:0]            ram_dout;
  logic                  ram_wr;
  logic                  stall_req;
  logic [4:0]            wb_wa;
  logic [31:0]           wb_wn;
  logic                  wb_we;

  modport master (
    input  ex_valid, ex_memop, ex_addr, ex_sdata, ex_wa, ex_wn, ex_we, ram_din,
    output ram_a, ram_dout, ram_wr, stall_req, wb_wa, wb_wn, wb_we
  );

  modport slave (
    output ex_valid, ex_memop, ex_addr, ex_sdata, ex_wa, ex_wn, ex_we, ram_din,
    input  ram_a, ram_dout, ram_wr, stall_req, wb_wa, wb_wn, wb_we
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access stage: byte-serial loads/stores over an 8-bit RAM bus,
// load extension, and the registered write-back triple for the register file.
module mem_access_stage #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  mem_access_stage_if.master bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;

  function automatic logic op_is_load(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd5);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op >= 4'd6) && (op <= 4'd8);
  endfunction

  function automatic logic [2:0] op_bytes(input logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 3'd1;
      OP_LH, OP_LHU, OP_SH: return 3'd2;
      default:              return 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
    case (i)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [3:0] op, input logic [31:0] raw);
    logic signed [31:0] ext;
    case (op)
      OP_LB:   ext = $signed({{24{raw[7]}}, raw[7:0]});
      OP_LH:   ext = $signed({{16{raw[15]}}, raw[15:0]});
      OP_LBU:  ext = $signed({24'd0, raw[7:0]});
      OP_LHU:  ext = $signed({16'd0, raw[15:0]});
      default: ext = $signed(raw);
    endcase
    return ext;
  endfunction

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [31:0]           cap_q, cap_d;
  logic [3:0]            op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           sdata_q;
  logic [4:0]            wa_q;
  logic                  we_q;

  logic [ADDR_WIDTH-1:0] ram_a_q, ram_a_d;
  logic [7:0]            ram_dout_q, ram_dout_d;
  logic                  ram_wr_q, ram_wr_d;
  logic [4:0]            wb_wa_q, wb_wa_d;
  logic [31:0]           wb_wn_q, wb_wn_d;
  logic                  wb_we_q, wb_we_d;

  logic                  latch_en;
  logic                  stall;
  logic [2:0]            nbytes;
  logic [1:0]            idx;
  logic [1:0]            nidx;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cap_d      = cap_q;
    ram_a_d    = ram_a_q;
    ram_dout_d = ram_dout_q;
    ram_wr_d   = 1'b0;
    wb_wa_d    = wb_wa_q;
    wb_wn_d    = wb_wn_q;
    wb_we_d    = 1'b0;
    latch_en   = 1'b0;
    stall      = 1'b0;
    nbytes     = op_bytes(op_q);
    idx        = 2'(cnt_q - 3'd1);
    nidx       = 2'(cnt_q + 3'd1);

    case (state_q)
      IDLE: begin
        if (bus.ex_valid) begin
          if (op_is_load(bus.ex_memop)) begin
            stall    = 1'b1;
            latch_en = 1'b1;
            state_d  = RD;
            cnt_d    = 3'd0;
            ram_a_d  = bus.ex_addr[ADDR_WIDTH-1:0];
          end else if (op_is_store(bus.ex_memop)) begin
            stall      = 1'b1;
            latch_en   = 1'b1;
            state_d    = WR;
            cnt_d      = 3'd0;
            ram_a_d    = bus.ex_addr[ADDR_WIDTH-1:0];
            ram_dout_d = bus.ex_sdata[7:0];
            ram_wr_d   = 1'b1;
          end else begin
            wb_wa_d = bus.ex_wa;
            wb_wn_d = bus.ex_wn;
            wb_we_d = bus.ex_we;
          end
        end
      end
      RD: begin
        stall = 1'b1;
        // RAM data lags the address by one cycle, so cycle cnt captures byte cnt-1
        if (cnt_q != 3'd0) begin
          case (idx)
            2'd0:    cap_d[7:0]   = bus.ram_din;
            2'd1:    cap_d[15:8]  = bus.ram_din;
            2'd2:    cap_d[23:16] = bus.ram_din;
            default: cap_d[31:24] = bus.ram_din;
          endcase
        end
        if (cnt_q == nbytes) begin
          state_d = DONE;
          wb_wa_d = wa_q;
          wb_wn_d = extend_load(op_q, cap_d);
          wb_we_d = we_q;
        end else begin
          cnt_d = cnt_q + 3'd1;
          if ((cnt_q + 3'd1) < nbytes) ram_a_d = addr_q + ADDR_WIDTH'(cnt_q + 3'd1);
        end
      end
      WR: begin
        stall = 1'b1;
        if (cnt_q == (nbytes - 3'd1)) begin
          state_d = DONE;
        end else begin
          cnt_d      = cnt_q + 3'd1;
          ram_a_d    = addr_q + ADDR_WIDTH'(cnt_q + 3'd1);
          ram_dout_d = byte_sel(sdata_q, nidx);
          ram_wr_d   = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (rst) stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      cap_q      <= 32'd0;
      ram_a_q    <= '0;
      ram_dout_q <= 8'd0;
      ram_wr_q   <= 1'b0;
      wb_wa_q    <= 5'd0;
      wb_wn_q    <= 32'd0;
      wb_we_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cap_q      <= cap_d;
      ram_a_q    <= ram_a_d;
      ram_dout_q <= ram_dout_d;
      ram_wr_q   <= ram_wr_d;
      wb_wa_q    <= wb_wa_d;
      wb_wn_q    <= wb_wn_d;
      wb_we_q    <= wb_we_d;
    end
  end

  // Transaction operands are held here so upstream changes during a stall have no effect
  always_ff @(posedge clk) begin
    if (latch_en) begin
      op_q    <= bus.ex_memop;
      addr_q  <= bus.ex_addr[ADDR_WIDTH-1:0];
      sdata_q <= bus.ex_sdata;
      wa_q    <= bus.ex_wa;
      we_q    <= bus.ex_we;
    end
  end

  assign bus.ram_a     = ram_a_q;
  assign bus.ram_dout  = ram_dout_q;
  assign bus.ram_wr    = ram_wr_q;
  assign bus.stall_req = stall;
  assign bus.wb_wa     = wb_wa_q;
  assign bus.wb_wn     = wb_wn_q;
  assign bus.wb_we     = wb_we_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: byte RAM model, table vectors, hand sequences and
// randomized transactions checked against a transaction-level reference.
module tb_mem_access_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_access_stage_if #(.ADDR_WIDTH(32)) bus ();

  mem_access_stage #(.ADDR_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // 4 KiB RAM indexed by the low address bits, read data one cycle after address
  logic [7:0]  mem [0:4095];
  logic        pl_en;
  logic [11:0] pl_addr;
  logic [7:0]  pl_data;

  always @(posedge clk) begin
    bus.ram_din <= mem[bus.ram_a[11:0]];
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.ram_wr) mem[bus.ram_a[11:0]] <= bus.ram_dout;
  end

  logic [36:0] wbq [$];
  logic [39:0] wrq [$];
  int          stall_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.wb_we)     wbq.push_back({bus.wb_wa, bus.wb_wn});
      if (bus.ram_wr)    wrq.push_back({bus.ram_a, bus.ram_dout});
      if (bus.stall_req) stall_cnt <= stall_cnt + 1;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic int nb(input logic [3:0] op);
    if (op == 4'd1 || op == 4'd4 || op == 4'd6) return 1;
    if (op == 4'd2 || op == 4'd5 || op == 4'd7) return 2;
    return 4;
  endfunction

  function automatic bit is_ld(input logic [3:0] op);
    return op >= 4'd1 && op <= 4'd5;
  endfunction

  function automatic bit is_st(input logic [3:0] op);
    return op >= 4'd6 && op <= 4'd8;
  endfunction

  // Little-endian value of N bytes from the RAM, then signed/unsigned interpretation
  function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] addr);
    logic [31:0] v;
    logic [31:0] a;
    v = 32'd0;
    for (int i = 0; i < nb(op); i++) begin
      a = addr + 32'(i);
      v = v + ({24'd0, mem[a[11:0]]} << (8 * i));
    end
    if (op == 4'd1 && v >= 32'd128)   v = v - 32'd256;
    if (op == 4'd2 && v >= 32'd32768) v = v - 32'd65536;
    return v;
  endfunction

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    @(posedge clk); #1;
    pl_en   = 1'b0;
  endtask

  task automatic run_txn(input string name, input bit valid, input logic [3:0] op,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] wa, input logic [31:0] wn, input logic we,
                         input logic [31:0] exp_wn, input bit exp_pulse,
                         input int exp_stall, input bit scr);
    int wb0, wr0, st0, k, nw;
    logic [31:0] ea, sh;
    wb0 = wbq.size();
    wr0 = wrq.size();
    @(posedge clk); #1;
    st0 = stall_cnt;
    bus.ex_valid = valid;
    bus.ex_memop = op;
    bus.ex_addr  = addr;
    bus.ex_sdata = sdata;
    bus.ex_wa    = wa;
    bus.ex_wn    = wn;
    bus.ex_we    = we;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!bus.stall_req) break;
      if (scr && k > 0) begin
        bus.ex_memop = 4'($urandom);
        bus.ex_addr  = $urandom;
        bus.ex_sdata = $urandom;
        bus.ex_wa    = 5'($urandom);
        bus.ex_wn    = $urandom;
        bus.ex_we    = 1'($urandom);
      end
    end
    chk({name, "/timeout"}, 64'(k == 20), 64'd0);
    @(posedge clk); #1;
    bus.ex_valid = 1'b0;
    bus.ex_memop = 4'($urandom);
    bus.ex_addr  = $urandom;
    bus.ex_sdata = $urandom;
    repeat (3) @(negedge clk);
    chk({name, "/stall_cycles"}, 64'(stall_cnt - st0), 64'(exp_stall));
    chk({name, "/wb_pulses"}, 64'(wbq.size() - wb0), 64'(exp_pulse));
    if (exp_pulse && wbq.size() > wb0)
      chk({name, "/wb_data"}, 64'(wbq[wb0]), 64'({wa, exp_wn}));
    nw = (valid && is_st(op)) ? nb(op) : 0;
    chk({name, "/ram_writes"}, 64'(wrq.size() - wr0), 64'(nw));
    for (int i = 0; i < nw; i++) begin
      if (wr0 + i < wrq.size()) begin
        ea = addr + 32'(i);
        sh = sdata >> (8 * i);
        chk($sformatf("%s/wr%0d", name, i), 64'(wrq[wr0 + i]), 64'({ea, sh[7:0]}));
      end
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  wa;
    logic [31:0] wn;
    logic        we;
    logic [31:0] exp_wn;
    logic        exp_pulse;
    int          exp_stall;
  } vec_t;

  vec_t tbl [15];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wb0, st0, k;
    logic [3:0]  op;
    logic [31:0] addr, sdata, wn, ewn;
    logic [4:0]  wa;
    logic        we, valid;

    tbl[0]  = '{4'd0,  32'h0,         32'h0,         5'd5,  32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 0};
    tbl[1]  = '{4'd3,  32'h100,       32'h0,         5'd3,  32'h0,         1'b1, 32'h1234_5678, 1'b1, 6};
    tbl[2]  = '{4'd1,  32'h20,        32'h0,         5'd7,  32'h0,         1'b1, 32'hFFFF_FF80, 1'b1, 3};
    tbl[3]  = '{4'd4,  32'h20,        32'h0,         5'd8,  32'h0,         1'b1, 32'h0000_0080, 1'b1, 3};
    tbl[4]  = '{4'd2,  32'h30,        32'h0,         5'd9,  32'h0,         1'b1, 32'hFFFF_F001, 1'b1, 4};
    tbl[5]  = '{4'd5,  32'h30,        32'h0,         5'd10, 32'h0,         1'b1, 32'h0000_F001, 1'b1, 4};
    tbl[6]  = '{4'd8,  32'h200,       32'hDEAD_BEEF, 5'd12, 32'h0,         1'b1, 32'h0,         1'b0, 5};
    tbl[7]  = '{4'd7,  32'hFFFF_FFFF, 32'h0000_A55A, 5'd13, 32'h0,         1'b1, 32'h0,         1'b0, 3};
    tbl[8]  = '{4'd3,  32'h200,       32'h0,         5'd14, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b1, 6};
    tbl[9]  = '{4'd5,  32'hFFFF_FFFF, 32'h0,         5'd15, 32'h0,         1'b1, 32'h0000_A55A, 1'b1, 4};
    tbl[10] = '{4'd12, 32'h0,         32'h0,         5'd16, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 1'b1, 0};
    tbl[11] = '{4'd1,  32'h100,       32'h0,         5'd17, 32'h0,         1'b0, 32'h0,         1'b0, 3};
    tbl[12] = '{4'd0,  32'h0,         32'h0,         5'd0,  32'h0000_BEEF, 1'b1, 32'h0000_BEEF, 1'b1, 0};
    tbl[13] = '{4'd6,  32'h20,        32'h0000_007F, 5'd18, 32'h0,         1'b1, 32'h0,         1'b0, 2};
    tbl[14] = '{4'd1,  32'h20,        32'h0,         5'd19, 32'h0,         1'b1, 32'h0000_007F, 1'b1, 3};

    rst = 1'b1;
    pl_en = 1'b0;
    pl_addr = 12'd0;
    pl_data = 8'd0;
    bus.ex_valid = 1'b0;
    bus.ex_memop = 4'd0;
    bus.ex_addr  = 32'd0;
    bus.ex_sdata = 32'd0;
    bus.ex_wa    = 5'd0;
    bus.ex_wn    = 32'd0;
    bus.ex_we    = 1'b0;

    @(posedge clk); #1;
    for (int i = 0; i < 4096; i++) poke(12'(i), 8'($urandom));
    poke(12'h100, 8'h78); poke(12'h101, 8'h56); poke(12'h102, 8'h34); poke(12'h103, 8'h12);
    poke(12'h020, 8'h80); poke(12'h030, 8'h01); poke(12'h031, 8'hF0);

    // Reset state, with a load offered so the stall gating is exercised
    bus.ex_valid = 1'b1;
    bus.ex_memop = 4'd3;
    @(negedge clk);
    chk("reset/stall_req", 64'(bus.stall_req), 64'd0);
    chk("reset/wb", 64'({bus.wb_we, bus.wb_wa, bus.wb_wn}), 64'd0);
    chk("reset/ram", 64'({bus.ram_wr, bus.ram_a, bus.ram_dout}), 64'd0);
    @(posedge clk); #1;
    bus.ex_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 15; i++)
      run_txn($sformatf("vec%0d", i), 1'b1, tbl[i].op, tbl[i].addr, tbl[i].sdata,
              tbl[i].wa, tbl[i].wn, tbl[i].we, tbl[i].exp_wn, tbl[i].exp_pulse,
              tbl[i].exp_stall, 1'b0);

    // LW followed directly by an ALU op presented as soon as the stall drops
    wb0 = wbq.size();
    @(posedge clk); #1;
    st0 = stall_cnt;
    bus.ex_valid = 1'b1; bus.ex_memop = 4'd3; bus.ex_addr = 32'h100;
    bus.ex_wa = 5'd3; bus.ex_wn = 32'd0; bus.ex_we = 1'b1;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!bus.stall_req) break;
    end
    chk("b2b/timeout", 64'(k == 20), 64'd0);
    @(posedge clk); #1;
    bus.ex_memop = 4'd0; bus.ex_wa = 5'd11; bus.ex_wn = 32'h55AA_55AA; bus.ex_we = 1'b1;
    @(negedge clk);
    chk("b2b/idle_cycle", 64'({bus.stall_req, bus.wb_we}), 64'd0);
    @(posedge clk); #1;
    bus.ex_valid = 1'b0;
    @(negedge clk);
    chk("b2b/alu_wb", 64'({bus.wb_we, bus.wb_wa, bus.wb_wn}), 64'({1'b1, 5'd11, 32'h55AA_55AA}));
    repeat (2) @(negedge clk);
    chk("b2b/pulses", 64'(wbq.size() - wb0), 64'd2);
    if (wbq.size() > wb0) chk("b2b/load_wb", 64'(wbq[wb0]), 64'({5'd3, 32'h1234_5678}));
    chk("b2b/stall_cycles", 64'(stall_cnt - st0), 64'd6);

    // Reset during the second byte of a word store
    wb0 = wbq.size();
    @(posedge clk); #1;
    bus.ex_valid = 1'b1; bus.ex_memop = 4'd8; bus.ex_addr = 32'h300;
    bus.ex_sdata = 32'h1122_3344; bus.ex_wa = 5'd1; bus.ex_we = 1'b1;
    @(negedge clk);
    chk("rstsw/accept_stall", 64'(bus.stall_req), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstsw/byte0", 64'({bus.ram_wr, bus.ram_a, bus.ram_dout}), 64'({1'b1, 32'h300, 8'h44}));
    @(posedge clk); #1;
    rst = 1'b1;
    bus.ex_valid = 1'b0;
    @(negedge clk);
    chk("rstsw/stall_in_reset", 64'(bus.stall_req), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rstsw/quiet%0d", i), 64'({bus.ram_wr, bus.wb_we, bus.stall_req}), 64'd0);
    end
    chk("rstsw/no_wb", 64'(wbq.size() - wb0), 64'd0);
    run_txn("rstsw/lbu", 1'b1, 4'd4, 32'h300, 32'h0, 5'd21, 32'h0, 1'b1,
            32'h0000_0044, 1'b1, 3, 1'b0);

    // Randomized transactions against the reference model
    for (int n = 0; n < 120; n++) begin
      valid = ($urandom % 8) != 0;
      op    = 4'($urandom);
      addr  = ($urandom % 4 == 0) ? 32'hFFFF_FFF0 + ($urandom % 16) : 32'h400 + ($urandom % 256);
      sdata = $urandom;
      wa    = 5'($urandom);
      wn    = $urandom;
      we    = 1'($urandom);
      ewn   = is_ld(op) ? ref_load(op, addr) : wn;
      run_txn($sformatf("rnd%0d", n), valid, op, addr, sdata, wa, wn, we, ewn,
              valid && !is_st(op) && we,
              !valid ? 0 : is_ld(op) ? nb(op) + 2 : is_st(op) ? nb(op) + 1 : 0,
              1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
